sram_responder: RTL and testbench

- Memory-side responder for the core's inst_sram_*/data_sram_* request buses.
- Serves instruction fetch (read-only port) and load/store (read/write port) from one shared word array, with fixed 1-cycle read latency matching the IF→ID and EX→MEM pipeline timing.
- Also decodes a small MMIO window: an LED register and an optional timer.
- Sits outside the core, between the core's SRAM ports and the testbench or SoC top.

---
 rtl/sram_responder.sv | 113 +++++++++++
 tb/tb_sram_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// sram_responder: shared word array behind inst/data SRAM ports, plus an MMIO
// window (LED, optional timer when SRAM_RESPONDER_TIMER_EN is defined). Rev 1.0
// ============================================================================
module sram_responder #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic [15:0]       mmio_off;
  logic              is_mmio;
  logic              ram_wr;
  logic              collide;
  logic              proto_err;
  logic [31:0]       ram_word;
  logic [31:0]       inst_word;
  logic [31:0]       mmio_word;
  logic [31:0]       timer_val;
  logic              unused_bits;

  assign inst_idx  = inst_sram_addr[ADDR_W+1:2];
  assign data_idx  = data_sram_addr[ADDR_W+1:2];
  assign mmio_off  = data_sram_addr[15:0];
  assign is_mmio   = (data_sram_addr[31:16] == MMIO_HI);
  assign ram_wr    = data_sram_en && (data_sram_wen != 4'h0) && !is_mmio;
  assign collide   = inst_sram_en && ram_wr && (inst_idx == data_idx);
  assign proto_err = inst_sram_en && ((inst_sram_wen != 4'h0) || (inst_sram_addr[1:0] != 2'b00));
  assign ram_word  = mem[data_idx];

  assign unused_bits = ^{inst_sram_wdata, inst_sram_addr};

  // Write-first across ports: a fetch colliding with a store sees the new lanes.
  always_comb begin
    inst_word = mem[inst_idx];
    for (int i = 0; i < 4; i++) begin
      if (collide && data_sram_wen[i]) inst_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  always_comb begin
    mmio_word = 32'h0;
    case (mmio_off)
      16'hF000: mmio_word = {16'h0, led};
      16'hE000: mmio_word = timer_val;
      default:  mmio_word = 32'h0;
    endcase
  end

  // rst in the sensitivity list only gates the write; the array itself is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
      led             <= 16'h0;
      err             <= 1'b0;
    end else begin
      if (inst_sram_en) inst_sram_rdata <= inst_word;
      if (data_sram_en) data_sram_rdata <= is_mmio ? mmio_word : ram_word;
      if (data_sram_en && is_mmio && (mmio_off == 16'hF000)) begin
        if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
      end
      if (proto_err) err <= 1'b1;
    end
  end

`ifdef SRAM_RESPONDER_TIMER_EN
  logic [31:0] timer;
  logic        timer_wr;

  assign timer_wr  = data_sram_en && is_mmio && (mmio_off == 16'hE000) && (data_sram_wen != 4'h0);
  assign timer_val = timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           timer <= 32'h0;
    else if (timer_wr) timer <= data_sram_wdata;
    else               timer <= timer + 32'h1;
  end
`else
  assign timer_val = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_sram_responder: directed stimulus with queue-based scoreboard. Rev 1.0
// ============================================================================
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'h0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_wdata = 32'h0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic        err;

  sram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .err             (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          port;   // 1 = instruction port, 0 = data port
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one-cycle latency means each expectation falls due at a known edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check(e.nm, e.port ? inst_sram_rdata : data_sram_rdata, e.exp);
      end
    end
  end

  task automatic drive(input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                       input logic de, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd);
    @(negedge clk);
    inst_sram_en    = ie;
    inst_sram_wen   = iw;
    inst_sram_addr  = ia;
    data_sram_en    = de;
    data_sram_wen   = dw;
    data_sram_addr  = da;
    data_sram_wdata = dd;
  endtask

  task automatic expect_rd(input bit port, input logic [31:0] v, input string nm);
    q.push_back('{cyc + 1, port, v, nm});
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    drive(1'b0, 4'h0, 32'h0, 1'b1, w, a, d);
  endtask

  task automatic dread(input logic [31:0] a, input logic [31:0] exp, input string nm);
    drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, a, 32'h0);
    expect_rd(1'b0, exp, nm);
  endtask

  initial begin
    #3;
    check("reset_inst_rdata", inst_sram_rdata, 32'h0);
    check("reset_data_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full-word round trip and byte-lane merge with read-first store data.
    dwrite(32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    dread(32'h8000_0010, 32'hDEAD_BEEF, "t1_roundtrip");
    dwrite(32'h8000_0010, 4'b0010, 32'h0000_AA00);
    expect_rd(1'b0, 32'hDEAD_BEEF, "t2_read_first");
    dread(32'h8000_0010, 32'hDEAD_AAEF, "t2_byte_lane");
    dread(32'h0000_0010, 32'hDEAD_AAEF, "ram_alias");

    // Cross-port collisions: full and partial lanes.
    dwrite(32'h0000_0018, 4'hF, 32'hAABB_CCDD);
    drive(1'b1, 4'h0, 32'h0000_0014, 1'b1, 4'hF, 32'h0000_0014, 32'h1122_3344);
    expect_rd(1'b1, 32'h1122_3344, "t3_collide_full");
    drive(1'b1, 4'h0, 32'h0000_0018, 1'b1, 4'b0101, 32'h0000_0018, 32'h0011_0022);
    expect_rd(1'b1, 32'hAA11_CC22, "t3_collide_merge");
    dread(32'h0000_0014, 32'h1122_3344, "t3_after_full");
    dread(32'h0000_0018, 32'hAA11_CC22, "t3_after_merge");

    // LED register and RAM word at the aliased index.
    dwrite(32'h0000_3000, 4'hF, 32'hCAFE_F00D);
    dwrite(32'hBFAF_F000, 4'hF, 32'h1234_5678);
    @(posedge clk); #2;
    check("t4_led_write", {16'h0, led}, 32'h0000_5678);
    dread(32'hBFAF_F000, 32'h0000_5678, "t4_led_read");
    dwrite(32'hBFAF_F000, 4'b1100, 32'hFFFF_FFFF);
    dwrite(32'hBFAF_F000, 4'b0001, 32'h0000_00AB);
    @(posedge clk); #2;
    check("t4_led_lanes", {16'h0, led}, 32'h0000_56AB);
    dread(32'hBFAF_F000, 32'h0000_56AB, "t4_led_read2");
    dread(32'h0000_3000, 32'hCAFE_F00D, "t4_alias_ram");
    dwrite(32'hBFAF_0004, 4'hF, 32'h5555_5555);
    dread(32'hBFAF_0004, 32'h0, "mmio_unmapped");

    // Protocol errors are sticky and never write the array.
    drive(1'b1, 4'h0, 32'h0000_0014, 1'b0, 4'h0, 32'h0, 32'h0);
    expect_rd(1'b1, 32'h1122_3344, "inst_fetch");
    @(posedge clk); #2;
    check("err_clean", {31'h0, err}, 32'h0);
    drive(1'b1, 4'b0001, 32'h0000_0014, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #2;
    check("t5_err_set", {31'h0, err}, 32'h1);
    drive(1'b1, 4'h0, 32'h0000_0015, 1'b0, 4'h0, 32'h0, 32'h0);
    expect_rd(1'b1, 32'h1122_3344, "misaligned_fetch");
    idle();
    idle();
    @(posedge clk); #2;
    check("t5_err_sticky", {31'h0, err}, 32'h1);
    dread(32'h0000_0014, 32'h1122_3344, "t5_array_unchanged");

    // Timer: loaded at one edge, incremented at the next, sampled at the third.
    dwrite(32'hBFAF_E000, 4'hF, 32'h0000_0100);
    idle();
`ifdef SRAM_RESPONDER_TIMER_EN
    dread(32'hBFAF_E000, 32'h0000_0101, "t6_timer");
`else
    dread(32'hBFAF_E000, 32'h0, "t6_timer_absent");
`endif

    dwrite(32'h0000_001C, 4'hF, 32'h7777_7777);
    dread(32'h0000_0010, 32'hDEAD_AAEF, "pre_reset_read");
    idle();
    @(posedge clk); #2;

    // Mid-run reset: outputs clear at once; a write under reset is dropped.
    @(negedge clk);
    rst             = 1'b1;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h0000_001C;
    data_sram_wdata = 32'h0BAD_F00D;
    #1;
    check("t5_rst_inst_rdata", inst_sram_rdata, 32'h0);
    check("t5_rst_data_rdata", data_sram_rdata, 32'h0);
    check("t5_rst_led", {16'h0, led}, 32'h0);
    check("t5_rst_err", {31'h0, err}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    dread(32'h0000_001C, 32'h7777_7777, "reset_write_dropped");
    idle();
    @(posedge clk); #3;

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no response expected %h", e.nm, e.exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
